// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit and the decoder that drives it.
// Contents: md_op encoding, MDU sequencing state encoding, default latencies.
// Imported by mdu, mdu_calc and the control-unit decoder.
package mdu_pkg;

  localparam int MD_OP_W = 4;

  // md_op encoding; codes 7..15 are reserved and treated as no-ops.
  localparam logic [MD_OP_W-1:0] MDOP_NONE  = 4'd0;
  localparam logic [MD_OP_W-1:0] MDOP_MULT  = 4'd1;
  localparam logic [MD_OP_W-1:0] MDOP_MULTU = 4'd2;
  localparam logic [MD_OP_W-1:0] MDOP_DIV   = 4'd3;
  localparam logic [MD_OP_W-1:0] MDOP_DIVU  = 4'd4;
  localparam logic [MD_OP_W-1:0] MDOP_MTHI  = 4'd5;
  localparam logic [MD_OP_W-1:0] MDOP_MTLO  = 4'd6;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MUL_RUN = 2'd1,
    S_DIV_RUN = 2'd2
  } mdu_state_t;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/mdu_calc.sv
// Combinational MULT/MULTU/DIV/DIVU datapath; zero latency, no state, no backpressure.
// Ports: op (md_op code), a (rs operand), b (rt operand) -> res_hi/res_lo (HI/LO result),
//        div_by_zero (DIV/DIVU with b==0; result must not be committed).
module mdu_calc
  import mdu_pkg::*;
(
  input  logic [MD_OP_W-1:0] op,
  input  logic [31:0]        a,
  input  logic [31:0]        b,
  output logic [31:0]        res_hi,
  output logic [31:0]        res_lo,
  output logic               div_by_zero
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] safe_b;
  logic [31:0] safe_abs_b;
  logic [31:0] quo_u;
  logic [31:0] rem_u;
  logic [31:0] quo_mag;
  logic [31:0] rem_mag;
  logic [31:0] quo_s;
  logic [31:0] rem_s;

  // Low 64 bits of the product of sign-extended operands is the signed product.
  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Guard the divisor so a zero divide never produces X; the result is discarded anyway.
  assign safe_b     = (b == 32'd0) ? 32'd1 : b;
  assign abs_a      = a[31] ? (~a + 32'd1) : a;
  assign abs_b      = b[31] ? (~b + 32'd1) : b;
  assign safe_abs_b = (abs_b == 32'd0) ? 32'd1 : abs_b;

  assign quo_u   = a / safe_b;
  assign rem_u   = a % safe_b;
  assign quo_mag = abs_a / safe_abs_b;
  assign rem_mag = abs_a % safe_abs_b;

  // Signed divide on magnitudes: quotient negated when signs differ, remainder follows
  // the dividend. 0x80000000 / -1 falls out naturally as quotient 0x80000000, remainder 0.
  assign quo_s = (a[31] ^ b[31]) ? (~quo_mag + 32'd1) : quo_mag;
  assign rem_s = a[31] ? (~rem_mag + 32'd1) : rem_mag;

  always_comb begin
    res_hi      = 32'd0;
    res_lo      = 32'd0;
    div_by_zero = 1'b0;
    case (op)
      MDOP_MULT: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
      end
      MDOP_MULTU: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
      end
      MDOP_DIV: begin
        res_hi      = rem_s;
        res_lo      = quo_s;
        div_by_zero = (b == 32'd0);
      end
      MDOP_DIVU: begin
        res_hi      = rem_u;
        res_lo      = quo_u;
        div_by_zero = (b == 32'd0);
      end
      default: begin
        res_hi = 32'd0;
        res_lo = 32'd0;
      end
    endcase
  end

endmodule

// File: rtl/mdu.sv
// Multiply/divide unit holding architectural HI/LO; result commits after a fixed busy period.
// Ports: clk, reset (async active-low), md_start/md_op/rs_val/rt_val (request from EX),
//        busy (registered, high while MULT/DIV in flight; new requests ignored), hi_out/lo_out.
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               md_start,
  input  logic [MD_OP_W-1:0] md_op,
  input  logic [31:0]        rs_val,
  input  logic [31:0]        rt_val,
  output logic               busy,
  output logic [31:0]        hi_out,
  output logic [31:0]        lo_out
);

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  mdu_state_t  state;
  logic [CW-1:0] counter;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] pend_hi;
  logic [31:0] pend_lo;
  logic        pend_skip;

  logic [31:0] calc_hi;
  logic [31:0] calc_lo;
  logic        calc_dbz;

  mdu_calc u_calc (
    .op          (md_op),
    .a           (rs_val),
    .b           (rt_val),
    .res_hi      (calc_hi),
    .res_lo      (calc_lo),
    .div_by_zero (calc_dbz)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      counter   <= '0;
      busy      <= 1'b0;
      hi        <= 32'd0;
      lo        <= 32'd0;
      pend_hi   <= 32'd0;
      pend_lo   <= 32'd0;
      pend_skip <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (md_start) begin
            case (md_op)
              MDOP_MULT, MDOP_MULTU: begin
                pend_hi   <= calc_hi;
                pend_lo   <= calc_lo;
                pend_skip <= 1'b0;
                counter   <= CW'(MULT_CYCLES);
                busy      <= 1'b1;
                state     <= S_MUL_RUN;
              end
              MDOP_DIV, MDOP_DIVU: begin
                pend_hi   <= calc_hi;
                pend_lo   <= calc_lo;
                // Divide by zero still occupies the unit but leaves HI/LO intact.
                pend_skip <= calc_dbz;
                counter   <= CW'(DIV_CYCLES);
                busy      <= 1'b1;
                state     <= S_DIV_RUN;
              end
              MDOP_MTHI: hi <= rs_val;
              MDOP_MTLO: lo <= rs_val;
              default: ;
            endcase
          end
        end
        S_MUL_RUN, S_DIV_RUN: begin
          // Requests arriving here are dropped; nothing in this branch looks at md_start.
          if (counter == CW'(1)) begin
            if (!pend_skip) begin
              hi <= pend_hi;
              lo <= pend_lo;
            end
            counter <= '0;
            busy    <= 1'b0;
            state   <= S_IDLE;
          end else begin
            counter <= counter - CW'(1);
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign hi_out = hi;
  assign lo_out = lo;

endmodule

// File: tb/tb_mdu.sv
module tb_mdu;
  import mdu_pkg::*;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk;
  logic        reset;
  logic        md_start;
  logic [3:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  int checks = 0;
  int errors = 0;

  // Architectural HI/LO as the reference model believes them to be.
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  mdu #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk      (clk),
    .reset    (reset),
    .md_start (md_start),
    .md_op    (md_op),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .busy     (busy),
    .hi_out   (hi_out),
    .lo_out   (lo_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: architectural result of one MD operation from plain arithmetic.
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic [31:0] nh, output logic [31:0] nl);
    longint        sp;
    longint unsigned up;
    int            sa, sb;
    nh = m_hi;
    nl = m_lo;
    lat = 0;
    sa = a;
    sb = b;
    case (op)
      MDOP_MULT: begin
        lat = MULT_N;
        sp = longint'(sa) * longint'(sb);
        nh = sp[63:32];
        nl = sp[31:0];
      end
      MDOP_MULTU: begin
        lat = MULT_N;
        up = 64'(a) * 64'(b);
        nh = up[63:32];
        nl = up[31:0];
      end
      MDOP_DIV: begin
        lat = DIV_N;
        if (b == 0) begin
        end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
          nl = 32'h80000000;
          nh = 32'd0;
        end else begin
          nl = sa / sb;
          nh = sa % sb;
        end
      end
      MDOP_DIVU: begin
        lat = DIV_N;
        if (b != 0) begin
          nl = a / b;
          nh = a % b;
        end
      end
      MDOP_MTHI: nh = a;
      MDOP_MTLO: nl = a;
      default: ;
    endcase
  endtask

  // Drives one request and waits for busy to fall. Reports busy length and whether
  // hi_out/lo_out moved while busy was high.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int bcnt, output bit early, output bit busy_at_start);
    logic [31:0] ph, pl;
    @(negedge clk);
    busy_at_start = busy;
    ph = hi_out;
    pl = lo_out;
    md_start = 1'b1;
    md_op    = op;
    rs_val   = a;
    rt_val   = b;
    @(negedge clk);
    md_start = 1'b0;
    md_op    = MDOP_NONE;
    bcnt  = 0;
    early = 1'b0;
    while (busy === 1'b1 && bcnt < 200) begin
      bcnt++;
      if (hi_out !== ph || lo_out !== pl) early = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic check_op(input string name, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b);
    int bcnt, lat;
    bit early, bs;
    logic [31:0] nh, nl;
    model(op, a, b, lat, nh, nl);
    issue(op, a, b, bcnt, early, bs);
    m_hi = nh;
    m_lo = nl;
    checks++;
    if (bs !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_in_start_cycle got=%0b want=0", name, bs);
    end
    checks++;
    if (bcnt != lat) begin
      errors++;
      $display("FAIL %s busy_cycles got=%0d want=%0d", name, bcnt, lat);
    end
    checks++;
    if (early) begin
      errors++;
      $display("FAIL %s hi/lo changed while busy", name);
    end
    checks++;
    if (hi_out !== nh || lo_out !== nl) begin
      errors++;
      $display("FAIL %s result got hi=%08h lo=%08h want hi=%08h lo=%08h",
               name, hi_out, lo_out, nh, nl);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    md_start = 1'b0;
    md_op = MDOP_NONE;
    rs_val = 0;
    rt_val = 0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    m_hi = 0;
    m_lo = 0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || hi_out !== 32'd0 || lo_out !== 32'd0) begin
      errors++;
      $display("FAIL reset_state got busy=%0b hi=%08h lo=%08h want 0/0/0", busy, hi_out, lo_out);
    end
  endtask

  task automatic test_mult();
    check_op("mult_neg3x7", MDOP_MULT, 32'hFFFFFFFD, 32'd7);
    checks++;
    if (hi_out !== 32'hFFFFFFFF || lo_out !== 32'hFFFFFFEB) begin
      errors++;
      $display("FAIL mult_const got hi=%08h lo=%08h want FFFFFFFF/FFFFFFEB", hi_out, lo_out);
    end
    check_op("multu_max_x2", MDOP_MULTU, 32'hFFFFFFFF, 32'd2);
    checks++;
    if (hi_out !== 32'h00000001 || lo_out !== 32'hFFFFFFFE) begin
      errors++;
      $display("FAIL multu_const got hi=%08h lo=%08h want 00000001/FFFFFFFE", hi_out, lo_out);
    end
  endtask

  task automatic test_div();
    check_op("div_neg7_2", MDOP_DIV, 32'hFFFFFFF9, 32'd2);
    checks++;
    if (hi_out !== 32'hFFFFFFFF || lo_out !== 32'hFFFFFFFD) begin
      errors++;
      $display("FAIL div_const got hi=%08h lo=%08h want FFFFFFFF/FFFFFFFD", hi_out, lo_out);
    end
    check_op("div_overflow", MDOP_DIV, 32'h80000000, 32'hFFFFFFFF);
    checks++;
    if (hi_out !== 32'd0 || lo_out !== 32'h80000000) begin
      errors++;
      $display("FAIL div_overflow_const got hi=%08h lo=%08h want 00000000/80000000", hi_out, lo_out);
    end
    check_op("div_7_neg2", MDOP_DIV, 32'd7, 32'hFFFFFFFE);
    check_op("divu_big", MDOP_DIVU, 32'hFFFFFFF9, 32'd2);
  endtask

  task automatic test_div_zero();
    check_op("divu_by_zero", MDOP_DIVU, 32'h11111111, 32'd0);
    check_op("div_by_zero", MDOP_DIV, 32'h80000001, 32'd0);
  endtask

  task automatic test_mthi_mtlo();
    @(negedge clk);
    md_start = 1'b1;
    md_op = MDOP_MTHI;
    rs_val = 32'h12345678;
    @(negedge clk);
    checks++;
    if (hi_out !== 32'h12345678 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mthi got hi=%08h busy=%0b want 12345678/0", hi_out, busy);
    end
    md_op = MDOP_MTLO;
    rs_val = 32'h9ABCDEF0;
    @(negedge clk);
    md_start = 1'b0;
    md_op = MDOP_NONE;
    m_hi = 32'h12345678;
    m_lo = 32'h9ABCDEF0;
    checks++;
    if (lo_out !== 32'h9ABCDEF0 || hi_out !== 32'h12345678 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mtlo got hi=%08h lo=%08h busy=%0b want 12345678/9ABCDEF0/0",
               hi_out, lo_out, busy);
    end
    // Reserved opcodes must not touch anything.
    check_op("op_none", MDOP_NONE, 32'hDEADBEEF, 32'd3);
    check_op("op_reserved", 4'd9, 32'hDEADBEEF, 32'd3);
  endtask

  task automatic test_ignore_while_busy();
    int bcnt, lat;
    logic [31:0] nh, nl;
    model(MDOP_MULT, 32'd1000, 32'd3, lat, nh, nl);
    @(negedge clk);
    md_start = 1'b1;
    md_op = MDOP_MULT;
    rs_val = 32'd1000;
    rt_val = 32'd3;
    @(negedge clk);
    // Busy now: try an MTLO, then a fresh MULT; both must be dropped.
    md_op = MDOP_MTLO;
    rs_val = 32'hCAFEF00D;
    bcnt = 1;
    @(negedge clk);
    md_op = MDOP_MULT;
    rs_val = 32'd7;
    rt_val = 32'd7;
    if (busy === 1'b1) bcnt++;
    @(negedge clk);
    md_start = 1'b0;
    md_op = MDOP_NONE;
    while (busy === 1'b1 && bcnt < 200) begin
      bcnt++;
      @(negedge clk);
    end
    m_hi = nh;
    m_lo = nl;
    checks++;
    if (bcnt != MULT_N) begin
      errors++;
      $display("FAIL ignore_busy_len got=%0d want=%0d", bcnt, MULT_N);
    end
    checks++;
    if (hi_out !== nh || lo_out !== nl) begin
      errors++;
      $display("FAIL ignore_busy_result got hi=%08h lo=%08h want %08h/%08h", hi_out, lo_out, nh, nl);
    end
  endtask

  task automatic test_reset_mid_div();
    bit stray;
    @(negedge clk);
    md_start = 1'b1;
    md_op = MDOP_DIV;
    rs_val = 32'd100;
    rt_val = 32'd7;
    @(negedge clk);
    md_start = 1'b0;
    md_op = MDOP_NONE;
    @(negedge clk);
    @(negedge clk);
    // Third busy cycle.
    reset = 1'b0;
    #1;
    m_hi = 0;
    m_lo = 0;
    checks++;
    if (busy !== 1'b0 || hi_out !== 32'd0 || lo_out !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid_div got busy=%0b hi=%08h lo=%08h want 0/0/0", busy, hi_out, lo_out);
    end
    @(negedge clk);
    reset = 1'b1;
    stray = 1'b0;
    for (int i = 0; i < DIV_N + 4; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || hi_out !== 32'd0 || lo_out !== 32'd0) stray = 1'b1;
    end
    checks++;
    if (stray) begin
      errors++;
      $display("FAIL reset_no_commit got busy=%0b hi=%08h lo=%08h want 0/0/0", busy, hi_out, lo_out);
    end
  endtask

  task automatic test_random();
    logic [3:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 24; i++) begin
      op = 4'($urandom_range(1, 6));
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'($urandom_range(0, 9));
        1: b = -32'($urandom_range(1, 9));
        default: b = $urandom;
      endcase
      if (i % 7 == 3) a = -a;
      check_op("random", op, a, b);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_mthi_mtlo();
    test_ignore_while_busy();
    test_random();
    test_reset_mid_div();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu.md
Name: mdu

Overview:
Multiply/divide unit for the EX stage of the five-stage `mips` pipeline. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests from EX and holds the architectural HI/LO registers. It models fixed multi-cycle latency and exports `busy`, so the hazard unit can stall MFHI/MFLO and back-to-back MD instructions in D.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (must be >=1).
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (must be >=1).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- md_start  in  1  one-cycle request strobe from EX; ignored while `busy` is 1.
- md_op  in  4  operation code (see package): NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6.
- rs_val  in  32  operand A: dividend, multiplicand, or MTHI/MTLO source.
- rt_val  in  32  operand B: divisor or multiplier.
- busy  out  1  registered; high while a MULT or DIV operation is in flight.
- hi_out  out  32  current HI register; feeds the MFHI path.
- lo_out  out  32  current LO register; feeds the MFLO path.

Behaviour:
- Reset (reset=0, asynchronous): HI=0, LO=0, busy=0, counter=0, state=IDLE. Any in-flight result is discarded.
- State machine: IDLE, MUL_RUN, DIV_RUN.
- IDLE, md_start=1, op MULT/MULTU:
  - Compute the 64-bit product combinationally and latch it into pend_hi/pend_lo.
  - Load counter=MULT_CYCLES; go to MUL_RUN.
- IDLE, md_start=1, op DIV/DIVU: same as above with DIV_CYCLES; go to DIV_RUN.
- IDLE, md_start=1, op MTHI: HI<=rs_val at this edge; no busy.
- IDLE, md_start=1, op MTLO: LO<=rs_val at this edge; no busy.
- IDLE, md_start=1, op NONE or codes 7-15: no effect.
- MUL_RUN/DIV_RUN: counter decrements each edge. At the edge where counter==1, HI<=pend_hi and LO<=pend_lo, counter becomes 0, and state returns to IDLE.
- busy = (state!=IDLE), registered.
- Timing: start sampled at edge T0 gives busy=1 for exactly N cycles (T0+1 .. T0+N). New HI/LO are visible in the cycle that busy falls.
- Hazard contract: busy is 0 in the start cycle itself. The hazard unit stalls D on (md_start | busy) when D holds an MD-class instruction.
- md_start while busy: ignored entirely. No restart, no HI/LO write, including MTHI/MTLO.
- hi_out/lo_out always show the committed HI/LO. Pending values are never exposed early.
- MULT: signed 32x32 giving a 64-bit result; HI = bits [63:32], LO = bits [31:0].
- MULTU: same as MULT with both operands unsigned.
- DIV (signed): LO = quotient truncated toward zero; HI = remainder, which takes the sign of the dividend.
- DIV overflow (0x80000000 / 0xFFFFFFFF): LO=0x80000000, HI=0.
- DIVU: unsigned quotient in LO, unsigned remainder in HI.
- Divisor==0 (DIV or DIVU): full DIV_CYCLES busy period still runs; HI/LO are left unchanged at completion.
- Reset asserted mid-operation: busy drops immediately (asynchronously); HI/LO=0; the pending result is never committed.

Decomposition:
- Package mdu_pkg holds:
  - md_op encoding localparams (MDOP_NONE..MDOP_MTLO, width 4);
  - state encoding (S_IDLE, S_MUL_RUN, S_DIV_RUN);
  - default latency constants.
- The decoder in the control unit imports the same package to generate md_op.
- Sub-module mdu_calc is natural: purely combinational and stateless. Inputs op, a, b; outputs res_hi, res_lo, div_by_zero. It keeps the arithmetic separate from the sequencing FSM in mdu.

Test Plan:
- MULT, rs=0xFFFFFFFD (-3), rt=7: busy=1 for 5 cycles; afterwards HI=0xFFFFFFFF, LO=0xFFFFFFEB. hi_out/lo_out stay at the prior values while busy.
- MULTU, rs=0xFFFFFFFF, rt=2: HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles.
- DIV, rs=0xFFFFFFF9 (-7), rt=2: busy for 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV overflow, rs=0x80000000, rt=0xFFFFFFFF: LO=0x80000000, HI=0.
- DIVU by zero: busy for 10 cycles, then HI/LO unchanged.
- MTHI 0x12345678 then MTLO 0x9ABCDEF0 on consecutive cycles, no busy: values appear after each edge.
- MTLO issued mid-MULT is ignored.
- reset=0 at busy cycle 3 of a DIV: busy=0 and HI=LO=0 immediately. After reset is released, busy stays 0 and nothing is committed.
